// File: rtl/uart_alu_ctrl.sv
// Sequences three UART bytes (A, B, opcode) into an external ALU and sends the result back.
// An inter-byte timeout abandons partial commands; bytes arriving while a result is in flight are dropped.
module uart_alu_ctrl #(
  parameter int N_BITS_DATA    = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  input  logic                   rx_done_i,
  input  logic                   tx_done_i,
  input  logic [N_BITS_DATA-1:0] alu_result_i,
  output logic [N_BITS_DATA-1:0] alu_a_o,
  output logic [N_BITS_DATA-1:0] alu_b_o,
  output logic [N_BITS_OP-1:0]   alu_op_o,
  output logic                   tx_start_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  state_t                 state_q, state_d;
  logic [N_BITS_DATA-1:0] a_q, a_d;
  logic [N_BITS_DATA-1:0] b_q, b_d;
  logic [N_BITS_OP-1:0]   op_q, op_d;
  logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   expire;

  // A byte arriving in the expiry cycle is checked first, so it always beats the timeout.
  assign expire = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = '0;
    case (state_q)
      IDLE: begin
        if (rx_done_i) begin
          a_d     = rx_data_i;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_i) begin
          b_d     = rx_data_i;
          state_d = WAIT_OP;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_OP: begin
        if (rx_done_i) begin
          op_d    = rx_data_i[N_BITS_OP-1:0];
          state_d = EXEC;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        tx_data_d  = alu_result_i;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign alu_op_o   = op_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q != IDLE);

endmodule
